uart_rx_peripheral: RTL
=======================

# uart_rx_peripheral

Receive-side UART peripheral: the counterpart of the existing TX peripheral on the core's serial link. It oversamples the serial input at 16x baud, deframes 8-bit characters with an optional parity bit, and buffers them in a show-ahead FIFO that the core pops one byte at a time. Line errors are reported as sticky flags that the core clears explicitly. Frame format, parity configuration and parameter names match the TX peripheral, so both ends of a link use the same settings.

## Interface
- CLK_FREQ, 50000000, core clock frequency in Hz
- BAUD_RATE, 115200, line baud rate
- FIFO_DEPTH, 256, receive FIFO entries; must be a power of two, at least 2
- PAR_EN, 1, 1 = parity bit present after the data bits
- PAR_TYPE, 0, 0 = even parity, 1 = odd parity
- i_uart_clk  input  1  core clock
- i_uart_rst_n  input  1  reset, asynchronous, active-low
- i_uart_rx_sdata  input  1  serial line, asynchronous to the clock, idle high
- i_uart_rx_rden  input  1  pop the FIFO head
- i_uart_rx_err_clr  input  1  clear all sticky error flags
- o_uart_rx_pdata  output  8  FIFO head byte, valid while o_uart_rx_valid is high
- o_uart_rx_valid  output  1  FIFO not empty
- o_uart_fifo_full  output  1  FIFO full
- o_uart_rx_par_err  output  1  sticky parity error
- o_uart_rx_frm_err  output  1  sticky framing error (stop bit sampled low)
- o_uart_rx_overrun  output  1  sticky: a good byte arrived while the FIFO was full

## Operation
- Input synchronizer: 2 flops on i_uart_rx_sdata, both reset to 1. All logic uses the synchronized line.
- Prescaler:
  - DIV = CLK_FREQ/(BAUD_RATE*16), integer truncation, minimum 1.
  - Counts 0..DIV-1 and raises a 1-cycle tick at DIV-1.
  - A 4-bit sample counter advances 0..15 on each tick.
  - Both counters clear on entry to START.
- FSM:
  - IDLE → START when the synchronized line is 0.
  - START: at sample 8, line high (false start) → IDLE; line low → DATA.
  - DATA: 8 bits, LSB first, each taken at sample 8 of its bit. After bit 7 → PARITY if PAR_EN, otherwise → STOP.
  - PARITY: compare the sampled bit with the computed parity (PAR_TYPE 0 even, 1 odd). A mismatch marks the byte bad and sets o_uart_rx_par_err.
  - STOP: sample at sample 8. Low → set o_uart_rx_frm_err and discard the byte.
  - In every case STOP → IDLE immediately after sample 8, giving half-bit margin for a back-to-back start.
- Push rule:
  - A byte with good parity and a good stop bit is pushed.
  - If the FIFO is full and not popped that cycle, the byte is dropped and o_uart_rx_overrun is set.
  - Push and pop in the same cycle on a full FIFO are both accepted.
- Pop: i_uart_rx_rden with the FIFO non-empty advances the head. i_uart_rx_rden with the FIFO empty is ignored.
- FIFO: read/write pointers of log2(FIFO_DEPTH)+1 bits; wrap-around is handled by the MSB. Full and empty are computed from the pointer compare.
- Error flags:
  - i_uart_rx_err_clr clears all three flags.
  - A set event in the same cycle as a clear wins (the flag stays 1).

## Timing
- Reset values: o_uart_rx_pdata 0, o_uart_rx_valid 0, o_uart_fifo_full 0, all error flags 0. FSM in IDLE, pointers 0.
- Reset mid-frame: the frame is abandoned and the FIFO is emptied. After reset release the FSM waits for the line to be 1 before it can accept a new start.
- Start detection: 2 clocks after the line falls, because of the synchronizer.
- Push: on the clock edge after the stop-bit sample-8 tick. o_uart_rx_valid and o_uart_rx_pdata update in the same cycle as the push.
- Pop: o_uart_rx_pdata shows the next entry on the cycle after the rden edge. o_uart_rx_valid falls in that cycle if the FIFO is now empty.
- Error flags assert on the clock after the sample tick that detects the error.
- Throughput: 1 byte per (10+PAR_EN)*16*DIV clocks sustained.

## Configuration
- UART_RX_MAJORITY_EN
  - Defined: every bit, including start, parity and stop, is the 2-of-3 majority of samples 7, 8 and 9. The decision is taken at sample 9.
  - Undefined: a single sample at sample 8 is used and the majority logic is absent.
- Both builds must pass the same test plan apart from the glitch scenario.

## Test plan
- Single byte, CLK_FREQ=1843200 (DIV=1), PAR_EN=1, PAR_TYPE=0, frame 0xA5 with even parity bit 0 → o_uart_rx_valid=1, o_uart_rx_pdata=0xA5, no flags set; pop → o_uart_rx_valid=0.
- Bad parity: 0x01 sent with parity bit 0 → nothing pushed; o_uart_rx_par_err=1 until i_uart_rx_err_clr.
- Framing: 0x3C sent with stop bit low → nothing pushed, o_uart_rx_frm_err=1; the next good frame 0x55 is received correctly.
- Overrun: FIFO_DEPTH=4, five frames 0x10..0x14 with no pops → o_uart_fifo_full=1, o_uart_rx_overrun=1; pops return 0x10..0x13 in order.
- False start: line low for 4 sample ticks, then high → FSM back in IDLE, nothing pushed. A low glitch on sample 8 only of a data bit 1 → bit still read as 1 with UART_RX_MAJORITY_EN; read as 0 without.
- Reset mid-frame: assert i_uart_rst_n low during DATA with 2 bytes in the FIFO → all outputs at reset values; after release a clean frame 0x7E is received.

Source files
------------

// File: rtl/uart_rx_peripheral.sv
// ============================================================================
//  Module      : uart_rx_peripheral
//  Description : 16x-oversampling UART receiver with optional parity, a
//                show-ahead receive FIFO and sticky line-error flags.
//                Optional build macro UART_RX_MAJORITY_EN selects 2-of-3
//                majority voting over samples 7/8/9 of every bit.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_rx_peripheral #(
    parameter int CLK_FREQ   = 50000000,
    parameter int BAUD_RATE  = 115200,
    parameter int FIFO_DEPTH = 256,
    parameter int PAR_EN     = 1,
    parameter int PAR_TYPE   = 0
) (
    input  logic       i_uart_clk,
    input  logic       i_uart_rst_n,
    input  logic       i_uart_rx_sdata,
    input  logic       i_uart_rx_rden,
    input  logic       i_uart_rx_err_clr,
    output logic [7:0] o_uart_rx_pdata,
    output logic       o_uart_rx_valid,
    output logic       o_uart_fifo_full,
    output logic       o_uart_rx_par_err,
    output logic       o_uart_rx_frm_err,
    output logic       o_uart_rx_overrun
);

    localparam int C_DIV_RAW = CLK_FREQ / (BAUD_RATE * 16);
    localparam int C_DIV     = (C_DIV_RAW < 1) ? 1 : C_DIV_RAW;
    localparam int C_PRE_W   = (C_DIV > 1) ? $clog2(C_DIV) : 1;
    localparam int C_ADDR_W  = $clog2(FIFO_DEPTH);
    localparam logic [C_PRE_W-1:0] C_PRE_MAX = C_PRE_W'(C_DIV - 1);
`ifdef UART_RX_MAJORITY_EN
    localparam logic [3:0] C_SMP_DECIDE = 4'd9;
`else
    localparam logic [3:0] C_SMP_DECIDE = 4'd8;
`endif

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic                r_sync1;
    logic                r_sync2;
    logic                w_rx;
    logic [1:0]          r_settle;
    logic                r_armed;
    logic [C_PRE_W-1:0]  r_pre;
    logic [3:0]          r_smp;
    logic                w_tick;
    logic                w_decide;
    logic                w_bit;
    logic [7:0]          r_shift;
    logic [2:0]          r_bitcnt;
    logic                r_bad;
    logic                w_par_exp;
    logic                w_par_err_set;
    logic                w_frm_err_set;
    logic                w_good;
    logic                w_push;
    logic                w_pop;
    logic                w_ovr_set;
    logic                w_empty;
    logic                w_full;
    logic [C_ADDR_W:0]   r_wr_ptr;
    logic [C_ADDR_W:0]   r_rd_ptr;
    logic [7:0]          r_mem [FIFO_DEPTH];
    logic                r_par_err;
    logic                r_frm_err;
    logic                r_overrun;

    always_ff @(posedge i_uart_clk or negedge i_uart_rst_n) begin
        if (!i_uart_rst_n) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= i_uart_rx_sdata;
            r_sync2 <= r_sync1;
        end
    end
    assign w_rx = r_sync2;

    // The synchronizer resets to 1, so it must flush before the line is trusted
    // as idle; otherwise a line held low across reset would look like a start.
    always_ff @(posedge i_uart_clk or negedge i_uart_rst_n) begin
        if (!i_uart_rst_n) begin
            r_settle <= 2'd0;
            r_armed  <= 1'b0;
        end else if (r_settle != 2'd2) begin
            r_settle <= r_settle + 2'd1;
        end else if (w_rx) begin
            r_armed <= 1'b1;
        end
    end

    always_ff @(posedge i_uart_clk or negedge i_uart_rst_n) begin
        if (!i_uart_rst_n) begin
            r_pre <= '0;
            r_smp <= 4'd0;
        end else if (r_state == S_IDLE) begin
            r_pre <= '0;
            r_smp <= 4'd0;
        end else if (w_tick) begin
            r_pre <= '0;
            r_smp <= r_smp + 4'd1;
        end else begin
            r_pre <= r_pre + C_PRE_W'(1);
        end
    end

    assign w_tick   = (r_pre == C_PRE_MAX);
    assign w_decide = w_tick && (r_smp == C_SMP_DECIDE);

`ifdef UART_RX_MAJORITY_EN
    logic r_s7;
    logic r_s8;

    always_ff @(posedge i_uart_clk or negedge i_uart_rst_n) begin
        if (!i_uart_rst_n) begin
            r_s7 <= 1'b1;
            r_s8 <= 1'b1;
        end else begin
            if (w_tick && (r_smp == 4'd7)) r_s7 <= w_rx;
            if (w_tick && (r_smp == 4'd8)) r_s8 <= w_rx;
        end
    end
    assign w_bit = (r_s7 & r_s8) | (r_s7 & w_rx) | (r_s8 & w_rx);
`else
    assign w_bit = w_rx;
`endif

    always_ff @(posedge i_uart_clk or negedge i_uart_rst_n) begin
        if (!i_uart_rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:   if (r_armed && !w_rx) w_state_nxt = S_START;
            S_START:  if (w_decide) w_state_nxt = w_bit ? S_IDLE : S_DATA;
            S_DATA:   if (w_decide && (r_bitcnt == 3'd7))
                          w_state_nxt = (PAR_EN != 0) ? S_PARITY : S_STOP;
            S_PARITY: if (w_decide) w_state_nxt = S_STOP;
            S_STOP:   if (w_decide) w_state_nxt = S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge i_uart_clk or negedge i_uart_rst_n) begin
        if (!i_uart_rst_n) begin
            r_shift  <= 8'h00;
            r_bitcnt <= 3'd0;
            r_bad    <= 1'b0;
        end else begin
            if (r_state == S_START) begin
                r_bitcnt <= 3'd0;
                r_bad    <= 1'b0;
            end
            if ((r_state == S_DATA) && w_decide) begin
                r_shift  <= {w_bit, r_shift[7:1]};
                r_bitcnt <= r_bitcnt + 3'd1;
            end
            if (w_par_err_set) r_bad <= 1'b1;
        end
    end

    assign w_par_exp     = (^r_shift) ^ (PAR_TYPE != 0);
    assign w_par_err_set = (r_state == S_PARITY) && w_decide && (w_bit != w_par_exp);
    assign w_frm_err_set = (r_state == S_STOP) && w_decide && !w_bit;
    assign w_good        = (r_state == S_STOP) && w_decide && w_bit && !r_bad;

    // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
    assign w_empty   = (r_wr_ptr == r_rd_ptr);
    assign w_full    = (r_wr_ptr[C_ADDR_W] != r_rd_ptr[C_ADDR_W]) &&
                       (r_wr_ptr[C_ADDR_W-1:0] == r_rd_ptr[C_ADDR_W-1:0]);
    assign w_pop     = i_uart_rx_rden && !w_empty;
    assign w_push    = w_good && (!w_full || w_pop);
    assign w_ovr_set = w_good && w_full && !w_pop;

    always_ff @(posedge i_uart_clk or negedge i_uart_rst_n) begin
        if (!i_uart_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + (C_ADDR_W + 1)'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + (C_ADDR_W + 1)'(1);
        end
    end

    always_ff @(posedge i_uart_clk) begin
        if (w_push) r_mem[r_wr_ptr[C_ADDR_W-1:0]] <= r_shift;
    end

    always_ff @(posedge i_uart_clk or negedge i_uart_rst_n) begin
        if (!i_uart_rst_n) begin
            r_par_err <= 1'b0;
            r_frm_err <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            r_par_err <= w_par_err_set | (r_par_err & ~i_uart_rx_err_clr);
            r_frm_err <= w_frm_err_set | (r_frm_err & ~i_uart_rx_err_clr);
            r_overrun <= w_ovr_set     | (r_overrun & ~i_uart_rx_err_clr);
        end
    end

    assign o_uart_rx_pdata   = w_empty ? 8'h00 : r_mem[r_rd_ptr[C_ADDR_W-1:0]];
    assign o_uart_rx_valid   = !w_empty;
    assign o_uart_fifo_full  = w_full;
    assign o_uart_rx_par_err = r_par_err;
    assign o_uart_rx_frm_err = r_frm_err;
    assign o_uart_rx_overrun = r_overrun;

endmodule

`default_nettype wire
